// File: rtl/centroid_measure.sv
// Object-mask centroid producer: accumulates mask-pixel coordinate sums per frame,
// divides at frame end and offers (z_x, z_y) on a valid/ready handshake.
module centroid_measure #(
    parameter int unsigned DISP_WIDTH = 11,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned ACC_W      = 33,
    parameter int unsigned CNT_W      = 22
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  pix_valid,
    input  logic                  pix_mask,
    input  logic                  pix_sof,
    input  logic                  pix_eol,
    input  logic                  pix_eof,
    output logic [DISP_WIDTH-1:0] z_x,
    output logic [DISP_WIDTH-1:0] z_y,
    output logic                  valid,
    input  logic                  ready,
    output logic [7:0]            drop_count
);

    localparam int unsigned STEP_W = $clog2(DISP_WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DIVIDE, ST_OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [DISP_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [ACC_W-1:0]      sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0]      rem_x_q, rem_x_d, rem_y_q, rem_y_d, den_q, den_d;
    logic [DISP_WIDTH-1:0] quo_x_q, quo_x_d, quo_y_q, quo_y_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [DISP_WIDTH-1:0] z_x_q, z_x_d, z_y_q, z_y_d;
    logic                  valid_q, valid_d;
    logic [7:0]            drop_q, drop_d;

    // Beat-level accumulation including the current pixel
    logic [DISP_WIDTH-1:0] cur_x, cur_y, inc_x, inc_y;
    logic [ACC_W-1:0]      base_sx, base_sy, acc_sx, acc_sy;
    logic [CNT_W-1:0]      base_cnt, acc_cnt;
    logic [ACC_W:0]        ext_sx, ext_sy;
    logic [CNT_W:0]        ext_cnt;
    logic                  eof_ok, bit_x, bit_y;
    logic [DISP_WIDTH-1:0] quo_x_nxt, quo_y_nxt;

    always_comb begin
        cur_x    = pix_sof ? '0 : x_q;
        cur_y    = pix_sof ? '0 : y_q;
        inc_x    = (cur_x == '1) ? cur_x : cur_x + DISP_WIDTH'(1);
        inc_y    = (cur_y == '1) ? cur_y : cur_y + DISP_WIDTH'(1);
        base_sx  = pix_sof ? '0 : sum_x_q;
        base_sy  = pix_sof ? '0 : sum_y_q;
        base_cnt = pix_sof ? '0 : cnt_q;
        ext_sx   = (ACC_W+1)'(base_sx) + (ACC_W+1)'(cur_x);
        ext_sy   = (ACC_W+1)'(base_sy) + (ACC_W+1)'(cur_y);
        ext_cnt  = (CNT_W+1)'(base_cnt) + (CNT_W+1)'(1);
        if (pix_mask) begin
            acc_sx  = ext_sx[ACC_W] ? '1 : ext_sx[ACC_W-1:0];
            acc_sy  = ext_sy[ACC_W] ? '1 : ext_sy[ACC_W-1:0];
            acc_cnt = ext_cnt[CNT_W] ? '1 : ext_cnt[CNT_W-1:0];
        end else begin
            acc_sx  = base_sx;
            acc_sy  = base_sy;
            acc_cnt = base_cnt;
        end
        eof_ok = pix_valid && pix_eof && (acc_cnt >= CNT_W'(MIN_PIXELS));
    end

    // Restoring divide step, both axes share the shifted divisor
    always_comb begin
        bit_x     = (rem_x_q >= den_q);
        bit_y     = (rem_y_q >= den_q);
        quo_x_nxt = {quo_x_q[DISP_WIDTH-2:0], bit_x};
        quo_y_nxt = {quo_y_q[DISP_WIDTH-2:0], bit_y};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        rem_x_d = rem_x_q;
        rem_y_d = rem_y_q;
        den_d   = den_q;
        quo_x_d = quo_x_q;
        quo_y_d = quo_y_q;
        step_d  = step_q;
        z_x_d   = z_x_q;
        z_y_d   = z_y_q;
        valid_d = valid_q;
        drop_d  = drop_q;

        if (pix_valid) begin
            if (pix_eof) begin
                sum_x_d = '0;
                sum_y_d = '0;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
            end else begin
                sum_x_d = acc_sx;
                sum_y_d = acc_sy;
                cnt_d   = acc_cnt;
                if (pix_eol) begin
                    x_d = '0;
                    y_d = inc_y;
                end else begin
                    x_d = inc_x;
                    y_d = cur_y;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (eof_ok) begin
                    rem_x_d = acc_sx;
                    rem_y_d = acc_sy;
                    den_d   = ACC_W'(acc_cnt) << (DISP_WIDTH - 1);
                    quo_x_d = '0;
                    quo_y_d = '0;
                    step_d  = STEP_W'(DISP_WIDTH - 1);
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                rem_x_d = bit_x ? rem_x_q - den_q : rem_x_q;
                rem_y_d = bit_y ? rem_y_q - den_q : rem_y_q;
                den_d   = den_q >> 1;
                quo_x_d = quo_x_nxt;
                quo_y_d = quo_y_nxt;
                if (step_q == '0) begin
                    z_x_d   = quo_x_nxt;
                    z_y_d   = quo_y_nxt;
                    valid_d = 1'b1;
                    state_d = ST_OUTPUT;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (eof_ok && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
            rem_x_q <= '0;
            rem_y_q <= '0;
            den_q   <= '0;
            quo_x_q <= '0;
            quo_y_q <= '0;
            step_q  <= '0;
            z_x_q   <= '0;
            z_y_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            den_q   <= den_d;
            quo_x_q <= quo_x_d;
            quo_y_q <= quo_y_d;
            step_q  <= step_d;
            z_x_q   <= z_x_d;
            z_y_q   <= z_y_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign z_x        = z_x_q;
    assign z_y        = z_y_q;
    assign valid      = valid_q;
    assign drop_count = drop_q;

endmodule
